// File: rtl/neuron_arbiter_if.sv
// Neuron-side 4-phase bundled-data channels: input (data_in/req_in/ack_in)
// and output (data_out/req_out/ack_out). The arbiter is the master.
interface neuron_arbiter_if;
   logic n_data_in;
   logic n_req_in;
   logic n_ack_in;
   logic n_data_out;
   logic n_req_out;
   logic n_ack_out;

   modport master (
      output n_data_in, n_req_in, n_ack_out,
      input  n_ack_in, n_data_out, n_req_out
   );

   modport slave (
      input  n_data_in, n_req_in, n_ack_out,
      output n_ack_in, n_data_out, n_req_out
   );
endinterface

// File: rtl/neuron_arbiter.sv
// Round-robin sharing of one asynchronous neuron among N_SRC spike sources,
// with output-spike re-timing. Define NEURON_ARB_TIMEOUT_EN for the ack timeout.
module neuron_arbiter #(
   parameter int N_SRC       = 4,
   parameter int SETUP_CYC   = 2,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_SRC-1:0]         src_req,
   input  logic [N_SRC-1:0]         src_data,
   output logic [N_SRC-1:0]         src_gnt,
   neuron_arbiter_if.master         nrn,
   output logic                     spike_valid,
   output logic                     spike_data,
   output logic [$clog2(N_SRC)-1:0] spike_src,
   output logic [CNT_W-1:0]         fire_count,
   output logic                     busy,
   output logic                     err_timeout
);

   localparam int IDX_W   = $clog2(N_SRC);
   localparam int SETUP_W = $clog2(SETUP_CYC + 1);
   localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);

`ifdef NEURON_ARB_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, SETUP, REQ, REL} in_state_t;
   typedef enum logic       {O_IDLE, O_ACK}         out_state_t;

   in_state_t          st;
   out_state_t         ost;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   rr_next;
   logic [IDX_W-1:0]   pick_idx;
   logic [SETUP_W-1:0] setup_cnt;
   logic [TO_W-1:0]    to_cnt;
   logic               to_expired;
   int                 cand;

   logic [SYNC_STAGES-1:0] ack_in_sync;
   logic [SYNC_STAGES-1:0] req_out_sync;
   logic [SYNC_STAGES-1:0] data_out_sync;
   logic                   ack_in_s;
   logic                   req_out_s;
   logic                   data_out_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_in_sync   <= '0;
         req_out_sync  <= '0;
         data_out_sync <= '0;
      end else begin
         ack_in_sync   <= (ack_in_sync   << 1) | SYNC_STAGES'(nrn.n_ack_in);
         req_out_sync  <= (req_out_sync  << 1) | SYNC_STAGES'(nrn.n_req_out);
         data_out_sync <= (data_out_sync << 1) | SYNC_STAGES'(nrn.n_data_out);
      end
   end

   assign ack_in_s   = ack_in_sync[SYNC_STAGES-1];
   assign req_out_s  = req_out_sync[SYNC_STAGES-1];
   assign data_out_s = data_out_sync[SYNC_STAGES-1];

   // Scan from the highest offset down so the lowest offset from rr_ptr wins.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      pick_idx = '0;
      cand     = 0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         cand = int'(rr_ptr) + i;
         if (cand >= N_SRC) cand = cand - N_SRC;
         if (src_req[IDX_W'(cand)]) pick_idx = IDX_W'(cand);
      end
   end

   assign rr_next    = (idx == IDX_W'(N_SRC - 1)) ? '0 : idx + 1'b1;
   assign to_expired = TIMEOUT_EN && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt <= '0;
      end else if (TIMEOUT_EN && st == REQ) begin
         to_cnt <= to_cnt + 1'b1;
      end else begin
         to_cnt <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st            <= IDLE;
         idx           <= '0;
         rr_ptr        <= '0;
         setup_cnt     <= '0;
         nrn.n_data_in <= 1'b0;
         nrn.n_req_in  <= 1'b0;
         src_gnt       <= '0;
         spike_src     <= '0;
         busy          <= 1'b0;
         err_timeout   <= 1'b0;
      end else begin
         // NOTE: state uses <= only; the pulse default below is overridden later in the same block.
         src_gnt <= '0;
         case (st)
            IDLE: begin
               if (|src_req) begin
                  idx           <= pick_idx;
                  nrn.n_data_in <= src_data[pick_idx];
                  setup_cnt     <= '0;
                  busy          <= 1'b1;
                  st            <= SETUP;
               end
            end
            SETUP: begin
               if (setup_cnt == SETUP_W'(SETUP_CYC - 1)) begin
                  nrn.n_req_in <= 1'b1;
                  st           <= REQ;
               end else begin
                  setup_cnt <= setup_cnt + 1'b1;
               end
            end
            REQ: begin
               if (ack_in_s) begin
                  nrn.n_req_in <= 1'b0;
                  st           <= REL;
               end else if (to_expired) begin
                  // Abandon without a grant; the request stays pending and rr moves on.
                  nrn.n_req_in <= 1'b0;
                  err_timeout  <= 1'b1;
                  rr_ptr       <= rr_next;
                  busy         <= 1'b0;
                  st           <= IDLE;
               end
            end
            REL: begin
               if (!ack_in_s) begin
                  src_gnt[idx] <= 1'b1;
                  spike_src    <= idx;
                  rr_ptr       <= rr_next;
                  busy         <= 1'b0;
                  st           <= IDLE;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ost           <= O_IDLE;
         nrn.n_ack_out <= 1'b0;
         spike_valid   <= 1'b0;
         spike_data    <= 1'b0;
         fire_count    <= '0;
      end else begin
         spike_valid <= 1'b0;
         case (ost)
            O_IDLE: begin
               if (req_out_s) begin
                  spike_data    <= data_out_s;
                  spike_valid   <= 1'b1;
                  nrn.n_ack_out <= 1'b1;
                  if (data_out_s && fire_count != '1) fire_count <= fire_count + 1'b1;
                  ost <= O_ACK;
               end
            end
            O_ACK: begin
               if (!req_out_s) begin
                  nrn.n_ack_out <= 1'b0;
                  ost           <= O_IDLE;
               end
            end
            default: ost <= O_IDLE;
         endcase
      end
   end

endmodule

// File: doc/neuron_arbiter.md
Name: neuron_arbiter

Overview:
- Clocked controller that shares one asynchronous neuron among N spike sources.
- Arbitrates source requests round-robin and drives the neuron's input 4-phase bundled-data handshake (data_in/req_in/ack_in).
- Independently accepts the neuron's output handshake (data_out/req_out/ack_out) and re-times output spikes into the clock domain.
- Sits between the spike-source fabric and a neuron instance; all neuron-side inputs are synchronised locally.

Parameters:
- N_SRC, 4, number of requesters (2..16)
- SETUP_CYC, 2, cycles n_data_in is held stable before n_req_in rises (bundled-data setup)
- SYNC_STAGES, 2, flop stages on each asynchronous neuron-side input (n_ack_in, n_req_out, n_data_out)
- CNT_W, 8, width of fire counter
- TIMEOUT_CYC, 255, ack wait limit in cycles (used only with NEURON_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- src_req  in  N_SRC  per-source request level; held until granted
- src_data  in  N_SRC  per-source spike data bit, valid while src_req high
- src_gnt  out  N_SRC  one-cycle pulse when that source's transfer completes
- n_data_in  out  1  data to neuron
- n_req_in  out  1  request to neuron
- n_ack_in  in  1  neuron input acknowledge (async)
- n_data_out  in  1  neuron output data (async, bundled with n_req_out)
- n_req_out  in  1  neuron output request (async)
- n_ack_out  out  1  acknowledge to neuron output
- spike_valid  out  1  one-cycle pulse per accepted neuron output
- spike_data  out  1  captured n_data_out, valid with spike_valid
- spike_src  out  $clog2(N_SRC)  index of most recent granted source
- fire_count  out  CNT_W  count of accepted outputs with data=1, saturating
- busy  out  1  input FSM not IDLE
- err_timeout  out  1  sticky handshake-timeout flag

Behaviour:
- Reset (async, immediate): all outputs 0; rr pointer=0; both FSMs to idle states; sync flops cleared.
- Input FSM IDLE: if any src_req, select first set bit at or after the rr pointer (wrapping); latch index and src_data; drive n_data_in; go to SETUP.
- SETUP: count SETUP_CYC cycles with n_data_in stable; then set n_req_in=1; go to REQ.
- REQ: wait for synced n_ack_in=1; then n_req_in=0; go to REL.
- REL: wait for synced n_ack_in=0; pulse src_gnt[idx] for 1 cycle; update spike_src=idx; rr pointer=(idx+1) mod N_SRC; go to IDLE. busy=0 the next cycle.
- n_data_in changes only in IDLE->SETUP; it holds its value after the transfer.
- Output FSM O_IDLE: on synced n_req_out=1, capture synced n_data_out, set n_ack_out=1, pulse spike_valid; if data=1 and fire_count<max, increment; go to O_ACK.
- O_ACK: wait for synced n_req_out=0; n_ack_out=0; go to O_IDLE.
- The output FSM runs concurrently with the input FSM; no ordering is imposed between them.
- Minimum latency from src_req rise to n_req_in rise: 1+SETUP_CYC cycles.
- A source dropping src_req mid-transfer does not abort the transfer; src_gnt is still pulsed.
- Simultaneous requests: exactly one is granted per transfer, in round-robin order.
- fire_count saturates at 2^CNT_W-1; it does not wrap.
- Neuron inputs that glitch shorter than SYNC_STAGES cycles are not required to be seen.

Optional Feature:
- Macro: NEURON_ARB_TIMEOUT_EN.
- Defined: a counter runs in REQ. If synced n_ack_in stays low for TIMEOUT_CYC cycles:
  - n_req_in is dropped and err_timeout is set (sticky until rst);
  - no src_gnt is pulsed and the rr pointer still advances;
  - the FSM returns to IDLE and the request stays pending.
- Undefined: REQ waits indefinitely; err_timeout is tied to 0.

Test Plan:
- Reset mid-transfer: assert rst during REQ -> n_req_in, n_ack_out, busy, src_gnt all 0 in the same cycle; after release the FSM is in IDLE with rr pointer=0.
- Single source: src_req=4'b0001, src_data=1 -> n_data_in=1 at cycle 1, n_req_in rises at cycle 3, src_gnt=4'b0001 one cycle after synced ack falls, spike_src=0.
- Contention: src_req=4'b1011 held -> grants in order 0,1,3,0; one transfer at a time; n_req_in never high between REL and the next SETUP.
- Neuron model with weight 4, thold 8: three data=1 transfers -> neuron fires; spike_valid pulses, fire_count increments to 1, n_ack_out follows the 4-phase sequence.
- Saturation with CNT_W=2: 5 output spikes with data=1 -> fire_count stops at 3.
- NEURON_ARB_TIMEOUT_EN with TIMEOUT_CYC=10 and n_ack_in stuck at 0 -> n_req_in drops after 10 cycles, err_timeout=1, no src_gnt pulse.
